uart_rx_fifo: RTL and testbench
===============================

// Module: uart_rx_fifo
// PURPOSE
//  Receive side paired with uart_tx: deserialises 8N1 frames from the pin into bytes.
//  Adds a 2-flop input synchroniser, 3-sample majority voting and start-bit glitch rejection.
//  Adds framing-error and break detection, and a show-ahead receive FIFO.
//  Sits between the RX pad and the MCU bus/register block, sharing baud_div with uart_tx.
// PARAMETERS
//  FIFO_DEPTH  4  receive FIFO entries; power of 2, >= 2
// PORTS
//  clk        in   1    system clock
//  rst_n      in   1    synchronous active-low reset
//  baud_div   in   16   clocks per bit; values < 4 are treated as 4; static while busy=1
//  rx         in   1    asynchronous serial input, idle high
//  rx_valid   out  1    FIFO non-empty; rx_data holds the head byte
//  rx_data    out  8    FIFO head (show-ahead)
//  rx_ready   in   1    pop strobe; ignored when rx_valid=0
//  rx_count   out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
//  frame_err  out  1    1-cycle pulse: stop bit sampled 0
//  overrun    out  1    1-cycle pulse: byte dropped, FIFO full
//  busy       out  1    FSM not in IDLE
// BEHAVIOUR
//  Reset (rst_n=0 at posedge):
//   - sync flops and vote history := 1; FSM := IDLE; FIFO emptied.
//   - rx_valid=0, rx_data=8'h00, rx_count=0, frame_err=0, overrun=0, busy=0.
//   - Reset mid-frame abandons the frame; no push, no error pulse.
//  Sync/vote: rxs = rx after 2 flops. hist[2:0] = last 3 rxs. bit value = majority(hist).
//  Counter cnt counts 0..B-1, where B = max(baud_div, 4) and H = B>>1.
//  FSM:
//   - IDLE: rxs=0 -> START, cnt:=0.
//   - START: at cnt==H vote; 0 -> DATA with cnt:=0, bitidx:=0; 1 -> IDLE (glitch, no flags).
//   - DATA: at cnt==B-1 vote, shift into byte LSB-first, cnt:=0; after bitidx==7 -> STOP.
//   - STOP: at cnt==B-1 vote.
//     - 1 -> push byte, go IDLE.
//     - 0 -> frame_err pulse, byte discarded, go BREAK_WAIT.
//   - BREAK_WAIT: stay until rxs==1, then IDLE. A held-low line yields exactly one frame_err.
//  Latency: push is the stop-sample cycle; rx_valid/rx_data update on the next posedge.
//  FIFO:
//   - Pop on rx_valid & rx_ready.
//   - Push when full without pop -> byte dropped, overrun pulse, contents unchanged.
//   - Push+pop same cycle (incl. full) -> both take effect, count unchanged, no overrun.
//   - Pointers wrap modulo FIFO_DEPTH.
//   - rx_data holds the last head value when empty; 8'h00 only after reset.
//  frame_err and overrun may pulse in the same cycle as unrelated pops.
// TESTING
//  1. baud_div=16, loopback uart_tx sends 8'hA5 -> one push; rx_valid=1, rx_data=8'hA5, rx_count=1, no flags.
//  2. Send 8'h00, 8'hFF, 8'h3C back-to-back, rx_ready=0 -> rx_count=3; pops return 00, FF, 3C in order.
//  3. FIFO_DEPTH=4, send 5 bytes with no pops -> 5th dropped, overrun pulses once, rx_count=4, head=1st byte.
//  4. Drive rx low for 3 clk then high (baud_div=16) -> FSM returns to IDLE; no push, no frame_err.
//  5. Frame 8'h55 with stop bit 0, then line high -> frame_err pulse once, rx_count unchanged; next 8'h12 received OK.
//  6. rx held low 40 bit times -> exactly one frame_err. rst_n=0 mid-frame of 8'h77 -> FIFO empty, busy=0, next frame OK.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver: 2-flop synchroniser, 3-sample majority vote, start-glitch rejection,
// framing-error/break handling and a show-ahead receive FIFO.
module uart_rx_fifo #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [15:0]                   baud_div,
   input  logic                          rx,
   output logic                          rx_valid,
   output logic [7:0]                    rx_data,
   input  logic                          rx_ready,
   output logic [$clog2(FIFO_DEPTH):0]   rx_count,
   output logic                          frame_err,
   output logic                          overrun,
   output logic                          busy
);

   localparam int AW = $clog2(FIFO_DEPTH);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK_WAIT} state_t;

   state_t        state, state_next;
   logic          sync1, rxs;
   logic [2:0]    hist;
   logic          vote;
   logic [15:0]   bit_len, half_len, cnt, cnt_next;
   logic [2:0]    bitidx, bitidx_next;
   logic [7:0]    shreg, shreg_next;
   logic          push, fe_set;

   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr, rd_next;
   logic [AW:0]   count, count_next;
   logic          full, pop, do_push;

   assign bit_len  = (baud_div < 16'd4) ? 16'd4 : baud_div;
   assign half_len = bit_len >> 1;
   assign vote     = (hist[0] & hist[1]) | (hist[0] & hist[2]) | (hist[1] & hist[2]);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1 <= 1'b1;
         rxs   <= 1'b1;
         hist  <= 3'b111;
      end else begin
         sync1 <= rx;
         rxs   <= sync1;
         hist  <= {hist[1:0], rxs};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         cnt    <= 16'd0;
         bitidx <= 3'd0;
         shreg  <= 8'h00;
      end else begin
         state  <= state_next;
         cnt    <= cnt_next;
         bitidx <= bitidx_next;
         shreg  <= shreg_next;
      end
   end

   // Start is qualified at mid-bit; data and stop are sampled one full bit later each.
   always_comb begin
      state_next  = state;
      cnt_next    = cnt + 16'd1;
      bitidx_next = bitidx;
      shreg_next  = shreg;
      push        = 1'b0;
      fe_set      = 1'b0;
      case (state)
         IDLE: begin
            cnt_next = 16'd0;
            if (!rxs) state_next = START;
         end
         START: begin
            if (cnt == half_len) begin
               cnt_next    = 16'd0;
               bitidx_next = 3'd0;
               state_next  = vote ? IDLE : DATA;
            end
         end
         DATA: begin
            if (cnt == bit_len - 16'd1) begin
               cnt_next    = 16'd0;
               shreg_next  = {vote, shreg[7:1]};
               bitidx_next = bitidx + 3'd1;
               if (bitidx == 3'd7) state_next = STOP;
            end
         end
         STOP: begin
            if (cnt == bit_len - 16'd1) begin
               cnt_next = 16'd0;
               if (vote) begin
                  push       = 1'b1;
                  state_next = IDLE;
               end else begin
                  fe_set     = 1'b1;
                  state_next = BREAK_WAIT;
               end
            end
         end
         BREAK_WAIT: begin
            cnt_next = 16'd0;
            if (rxs) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign full     = (count == (AW+1)'(FIFO_DEPTH));
   assign rx_valid = (count != '0);
   assign pop      = rx_valid & rx_ready;
   assign do_push  = push & (~full | pop);
   assign rd_next  = pop ? rd_ptr + AW'(1) : rd_ptr;
   assign rx_count = count;
   assign busy     = (state != IDLE);

   always_comb begin
      count_next = count;
      if (do_push && !pop)      count_next = count + (AW+1)'(1);
      else if (!do_push && pop) count_next = count - (AW+1)'(1);
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= shreg;
   end

   // rx_data is a registered copy of the next head; a byte written this cycle bypasses mem.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         rx_data   <= 8'h00;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         rd_ptr    <= rd_next;
         count     <= count_next;
         frame_err <= fe_set;
         overrun   <= push & full & ~pop;
         if (count_next != '0)
            rx_data <= (do_push && rd_next == wr_ptr) ? shreg : mem[rd_next];
      end
   end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: frames driven on rx, expected bytes queued and
// checked by a monitor whenever the bench pops the FIFO.
module tb_uart_rx_fifo;

   localparam int DEPTH = 4;
   localparam int BIT   = 16;

   logic                       clk = 1'b0;
   logic                       rst_n = 1'b0;
   logic [15:0]                baud_div = 16'(BIT);
   logic                       rx = 1'b1;
   logic                       rx_valid;
   logic [7:0]                 rx_data;
   logic                       rx_ready = 1'b0;
   logic [$clog2(DEPTH):0]     rx_count;
   logic                       frame_err;
   logic                       overrun;
   logic                       busy;

   logic [7:0] exp_q[$];
   logic [7:0] mon_exp;
   int errors = 0;
   int checks = 0;
   int fe_seen = 0, ov_seen = 0, fe_exp = 0, ov_exp = 0;

   always #5 clk = ~clk;

   uart_rx_fifo #(.FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .baud_div(baud_div), .rx(rx),
      .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
      .rx_count(rx_count), .frame_err(frame_err), .overrun(overrun), .busy(busy)
   );

   // Monitor: counts flag pulses and scores every byte the bench pops.
   always @(negedge clk) begin
      if (frame_err) fe_seen++;
      if (overrun) ov_seen++;
      if (rst_n && rx_valid && rx_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL pop_unexpected actual=%h required=none", rx_data);
         end else begin
            mon_exp = exp_q.pop_front();
            if (rx_data !== mon_exp) begin
               errors++;
               $display("[TB] FAIL pop_data actual=%h required=%h", rx_data, mon_exp);
            end
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic sendBits(input logic [9:0] bits);
      for (int i = 0; i < 10; i++) begin
         rx = bits[i];
         idle(BIT);
      end
      rx = 1'b1;
   endtask

   task automatic applyStimulus(input logic [7:0] b, input logic stop_bit);
      sendBits({stop_bit, b, 1'b0});
      if (!stop_bit) fe_exp++;
      else if (exp_q.size() < DEPTH) exp_q.push_back(b);
      else ov_exp++;
   endtask

   task automatic drainFifo();
      rx_ready = 1'b1;
      for (int i = 0; i < 4 * DEPTH; i++) begin
         @(negedge clk);
         if (!rx_valid) break;
      end
      rx_ready = 1'b0;
      checkOutput("drain_empty", {31'd0, rx_valid}, 32'd0);
      checkOutput("drain_queue", exp_q.size(), 32'd0);
      idle(1);
   endtask

   task automatic checkFlags(input string tag);
      checkOutput({tag, "_frame_err_cnt"}, fe_seen, fe_exp);
      checkOutput({tag, "_overrun_cnt"}, ov_seen, ov_exp);
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      idle(3);
      checkOutput("reset_valid", {31'd0, rx_valid}, 32'd0);
      checkOutput("reset_data", {24'd0, rx_data}, 32'h00);
      checkOutput("reset_count", {29'd0, rx_count}, 32'd0);
      checkOutput("reset_busy", {31'd0, busy}, 32'd0);
      checkOutput("reset_flags", {30'd0, frame_err, overrun}, 32'd0);
      rst_n = 1'b1;
      idle(4);

      applyStimulus(8'hA5, 1'b1);
      idle(4);
      checkOutput("t1_valid", {31'd0, rx_valid}, 32'd1);
      checkOutput("t1_data", {24'd0, rx_data}, 32'hA5);
      checkOutput("t1_count", {29'd0, rx_count}, 32'd1);
      checkFlags("t1");
      drainFifo();

      applyStimulus(8'h00, 1'b1);
      applyStimulus(8'hFF, 1'b1);
      applyStimulus(8'h3C, 1'b1);
      idle(4);
      checkOutput("t2_count", {29'd0, rx_count}, 32'd3);
      checkOutput("t2_head", {24'd0, rx_data}, 32'h00);
      drainFifo();

      applyStimulus(8'h11, 1'b1);
      applyStimulus(8'h22, 1'b1);
      applyStimulus(8'h33, 1'b1);
      applyStimulus(8'h44, 1'b1);
      applyStimulus(8'h55, 1'b1);
      idle(4);
      checkOutput("t3_count", {29'd0, rx_count}, 32'd4);
      checkOutput("t3_head", {24'd0, rx_data}, 32'h11);
      checkOutput("t3_overrun_cnt", ov_seen, 32'd1);
      drainFifo();
      checkFlags("t3");

      rx = 1'b0;
      idle(3);
      rx = 1'b1;
      idle(3 * BIT);
      checkOutput("t4_busy", {31'd0, busy}, 32'd0);
      checkOutput("t4_count", {29'd0, rx_count}, 32'd0);
      checkFlags("t4");

      applyStimulus(8'h55, 1'b0);
      idle(BIT);
      checkOutput("t5_frame_err_cnt", fe_seen, 32'd1);
      checkOutput("t5_count", {29'd0, rx_count}, 32'd0);
      checkOutput("t5_busy", {31'd0, busy}, 32'd0);
      applyStimulus(8'h12, 1'b1);
      idle(4);
      checkOutput("t5_next_count", {29'd0, rx_count}, 32'd1);
      checkOutput("t5_next_data", {24'd0, rx_data}, 32'h12);
      drainFifo();

      rx = 1'b0;
      idle(40 * BIT);
      rx = 1'b1;
      fe_exp++;
      idle(2 * BIT);
      checkOutput("t6_break_frame_err_cnt", fe_seen, 32'd2);
      checkFlags("t6_break");
      checkOutput("t6_break_busy", {31'd0, busy}, 32'd0);
      checkOutput("t6_break_count", {29'd0, rx_count}, 32'd0);

      // Start bit plus three data bits of 8'h77, then reset mid-frame.
      rx = 1'b0;
      idle(BIT);
      rx = 1'b1;
      idle(3 * BIT);
      checkOutput("t6_midframe_busy", {31'd0, busy}, 32'd1);
      rst_n = 1'b0;
      idle(2);
      checkOutput("t6_rst_busy", {31'd0, busy}, 32'd0);
      checkOutput("t6_rst_valid", {31'd0, rx_valid}, 32'd0);
      checkOutput("t6_rst_count", {29'd0, rx_count}, 32'd0);
      checkOutput("t6_rst_data", {24'd0, rx_data}, 32'h00);
      rst_n = 1'b1;
      idle(4);
      applyStimulus(8'h77, 1'b1);
      idle(4);
      checkOutput("t6_after_count", {29'd0, rx_count}, 32'd1);
      checkOutput("t6_after_data", {24'd0, rx_data}, 32'h77);
      drainFifo();
      checkFlags("final");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
